// File: rtl/tap_seq_ctrl.sv
// Tap-tempo sequencer: measures tap intervals, averages the last N_AVG and drives per2bpm.
// Latency: press to btn_per_valid_o is 2 cycles (capture, REQ); bpm_update_o 1 cycle after bpm_valid_i.
// Backpressure: one request outstanding; presses during a request coalesce into one follow-up.
module tap_seq_ctrl #(
  parameter int N_AVG      = 4,
  parameter int PER_W      = 24,
  parameter int TIMEOUT_TP = 9766
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tp_i,
  input  logic             btn_press_i,
  output logic [PER_W-1:0] btn_per_o,
  output logic             btn_per_valid_o,
  input  logic [7:0]       bpm_i,
  input  logic             bpm_valid_i,
  output logic [7:0]       bpm_o,
  output logic             bpm_update_o,
  output logic             active_o
);

  localparam int SHIFT = $clog2(N_AVG);
  localparam int PTR_W = (N_AVG > 1) ? $clog2(N_AVG) : 1;
  localparam int SUM_W = PER_W + SHIFT;
  localparam logic [PER_W-1:0] TMO_CNT  = PER_W'(TIMEOUT_TP);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_AVG - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t           state;
  logic [PER_W-1:0] cnt;
  logic [PER_W-1:0] ring [N_AVG];
  logic [PTR_W-1:0] ptr;
  logic             ring_empty;
  logic             pend;
  logic             tmo;

  logic             tmo_hit;
  logic             rec_press;
  logic             pend_nxt;
  logic             tmo_nxt;
  logic [SUM_W-1:0] sum;
  logic [PER_W-1:0] avg;

  // Press bookkeeping shared by the counter, ring and FSM; a press also cancels a pending timeout.
  always_comb begin
    tmo_hit   = (cnt == TMO_CNT);
    rec_press = btn_press_i && (state != S_IDLE);
    pend_nxt  = pend | btn_press_i;
    tmo_nxt   = btn_press_i ? 1'b0 : (tmo | tmo_hit);
  end

  // Running average of the ring, truncated.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N_AVG; i++) begin
      sum = sum + SUM_W'(ring[i]);
    end
    avg = PER_W'(sum >> SHIFT);
  end

  // Interval counter: counts timepulses, saturates at the timeout, restarts on a press.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (btn_press_i) begin
      cnt <= tp_i ? PER_W'(1) : '0;
    end else if (tp_i && (cnt != TMO_CNT)) begin
      cnt <= cnt + PER_W'(1);
    end
  end

  // Interval ring: the first interval of a sequence fills every slot, later ones replace the oldest.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr        <= '0;
      ring_empty <= 1'b1;
      for (int i = 0; i < N_AVG; i++) begin
        ring[i] <= '0;
      end
    end else if ((state == S_IDLE) && btn_press_i) begin
      ring_empty <= 1'b1;
    end else if (rec_press) begin
      if (ring_empty) begin
        ring_empty <= 1'b0;
        for (int i = 0; i < N_AVG; i++) begin
          ring[i] <= cnt;
        end
      end else begin
        ring[ptr] <= cnt;
        ptr       <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
      end
    end
  end

  // Sequence FSM with registered request, display and activity outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      pend            <= 1'b0;
      tmo             <= 1'b0;
      btn_per_o       <= '0;
      btn_per_valid_o <= 1'b0;
      bpm_o           <= '0;
      bpm_update_o    <= 1'b0;
      active_o        <= 1'b0;
    end else begin
      btn_per_valid_o <= 1'b0;
      bpm_update_o    <= 1'b0;
      case (state)
        S_IDLE: begin
          pend <= 1'b0;
          tmo  <= 1'b0;
          if (btn_press_i) begin
            state    <= S_MEASURE;
            active_o <= 1'b1;
          end
        end
        S_MEASURE: begin
          if (btn_press_i) begin
            state <= S_REQ;
          end else if (tmo_hit) begin
            state    <= S_IDLE;
            active_o <= 1'b0;
          end
        end
        S_REQ: begin
          btn_per_o       <= avg;
          btn_per_valid_o <= 1'b1;
          state           <= S_WAIT;
          pend            <= btn_press_i;
          tmo             <= tmo_nxt;
        end
        S_WAIT: begin
          if (bpm_valid_i) begin
            bpm_o        <= bpm_i;
            bpm_update_o <= 1'b1;
            pend         <= 1'b0;
            if (pend_nxt) begin
              state <= S_REQ;
              tmo   <= tmo_nxt;
            end else if (tmo_nxt) begin
              state    <= S_IDLE;
              active_o <= 1'b0;
              tmo      <= 1'b0;
            end else begin
              state <= S_MEASURE;
              tmo   <= 1'b0;
            end
          end else begin
            pend <= pend_nxt;
            tmo  <= tmo_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tap_seq_ctrl.sv
// Bench for tap_seq_ctrl: table of taps plus hand sequences, per2bpm stub replying after 20 clocks.
// Latency: requests and results are checked by scoreboard queues as the DUT produces them.
// Backpressure: the stub serves one request at a time; overlapping requests are flagged.
module tb_tap_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        tp;
  logic        btn_press;
  logic [23:0] btn_per;
  logic        btn_per_valid;
  logic [7:0]  bpm_in;
  logic        bpm_valid;
  logic [7:0]  bpm_out;
  logic        bpm_update;
  logic        active;

  int total = 0;
  int bad   = 0;
  int req_q[$];
  int bpm_q[$];
  int stub_bpm  = 0;
  bit stub_mute = 0;

  typedef struct {
    int gap;
    bit press;
    int exp_req;
    int stub_val;
    bit exp_active;
    int exp_bpm;
  } row_t;

  row_t tbl[8];

  tap_seq_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .tp_i            (tp),
    .btn_press_i     (btn_press),
    .btn_per_o       (btn_per),
    .btn_per_valid_o (btn_per_valid),
    .bpm_i           (bpm_in),
    .bpm_valid_i     (bpm_valid),
    .bpm_o           (bpm_out),
    .bpm_update_o    (bpm_update),
    .active_o        (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tp_run(input int n);
    if (n > 0) begin
      tp = 1'b1;
      repeat (n) @(posedge clk);
      #1 tp = 1'b0;
    end
  endtask

  task automatic press(input bit with_tp);
    btn_press = 1'b1;
    tp        = with_tp;
    @(posedge clk);
    #1;
    btn_press = 1'b0;
    tp        = 1'b0;
  endtask

  task automatic expect_req(input int v);
    req_q.push_back(v);
  endtask

  // per2bpm stub: answers each request 20 clocks later with the value current at request time
  initial begin
    int v;
    bpm_in    = '0;
    bpm_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (btn_per_valid) begin
        v = stub_bpm;
        repeat (20) @(posedge clk);
        #1;
        bpm_in    = 8'(v);
        bpm_valid = 1'b1;
        if (!stub_mute) bpm_q.push_back(v);
        @(posedge clk);
        #1 bpm_valid = 1'b0;
      end
    end
  end

  // Output monitor: scoreboards requests and display updates, watches request overlap
  initial begin
    bit outstanding = 0;
    bit prev_vld    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 0;
      end else begin
        if (btn_per_valid) begin
          if (req_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_req: got btn_per=%0d want no request", btn_per);
          end else begin
            check("req_value", int'(btn_per), req_q.pop_front());
          end
          check("req_overlap", int'(outstanding), 0);
          check("req_back_to_back", int'(prev_vld), 0);
          outstanding = 1;
        end
        if (bpm_valid) outstanding = 0;
        if (bpm_update) begin
          if (bpm_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_update: got bpm_o=%0d want no update", bpm_out);
          end else begin
            check("bpm_value", int'(bpm_out), bpm_q.pop_front());
          end
        end
      end
      prev_vld = btn_per_valid;
    end
  end

  initial begin
    rst       = 1'b1;
    tp        = 1'b0;
    btn_press = 1'b0;

    //            gap   press req   stub act bpm
    tbl[0] = '{    0,  1,   -1,   0,  1,   0};
    tbl[1] = '{ 2441,  1, 2441, 120,  1, 120};
    tbl[2] = '{ 9766,  0,   -1,   0,  0, 120};
    tbl[3] = '{    5,  1,   -1,   0,  1, 120};
    tbl[4] = '{ 2000,  1, 2000, 100,  1, 100};
    tbl[5] = '{ 2000,  1, 2000, 101,  1, 101};
    tbl[6] = '{ 2000,  1, 2000, 102,  1, 102};
    tbl[7] = '{ 3000,  1, 2250,  90,  1,  90};

    idle(3);
    check("rst_btn_per", int'(btn_per), 0);
    check("rst_btn_per_valid", int'(btn_per_valid), 0);
    check("rst_bpm", int'(bpm_out), 0);
    check("rst_bpm_update", int'(bpm_update), 0);
    check("rst_active", int'(active), 0);
    rst = 1'b0;
    idle(2);

    // First tap, interval requests, timeout and restart, 4-deep averaging
    for (int r = 0; r < 8; r++) begin
      tp_run(tbl[r].gap);
      if (tbl[r].press) begin
        stub_bpm = tbl[r].stub_val;
        if (tbl[r].exp_req >= 0) expect_req(tbl[r].exp_req);
        press(1'b0);
      end
      idle(40);
      check($sformatf("row%0d_active", r), int'(active), int'(tbl[r].exp_active));
      check($sformatf("row%0d_bpm", r), int'(bpm_out), tbl[r].exp_bpm);
    end

    // Two presses while waiting: one follow-up request with the latest average
    stub_bpm = 77;
    tp_run(1000);
    expect_req(2000);
    press(1'b0);
    idle(3);
    stub_bpm = 78;
    tp_run(4);
    press(1'b0);
    tp_run(6);
    expect_req(1002);
    press(1'b0);
    idle(80);
    check("coalesce_bpm", int'(bpm_out), 78);
    check("coalesce_active", int'(active), 1);

    // Press coincident with tp: captured value excludes it, counter restarts at 1
    stub_bpm = 60;
    tp_run(10);
    expect_req(255);
    press(1'b1);
    idle(40);
    stub_bpm = 61;
    tp_run(5);
    expect_req(6);
    press(1'b0);
    idle(40);
    check("coinc_tp_bpm", int'(bpm_out), 61);

    // Press in the timeout cycle wins and keeps the sequence running
    stub_bpm = 62;
    tp_run(9766);
    expect_req(2447);
    press(1'b1);
    idle(40);
    check("press_at_timeout_active", int'(active), 1);
    check("press_at_timeout_bpm", int'(bpm_out), 62);

    // Reset while waiting: request abandoned, late strobe ignored
    stub_bpm = 99;
    tp_run(8);
    expect_req(2447);
    press(1'b0);
    idle(6);
    stub_mute = 1'b1;
    rst = 1'b1;
    idle(2);
    check("wait_rst_btn_per", int'(btn_per), 0);
    check("wait_rst_btn_per_valid", int'(btn_per_valid), 0);
    check("wait_rst_bpm", int'(bpm_out), 0);
    check("wait_rst_active", int'(active), 0);
    rst = 1'b0;
    idle(40);
    check("late_strobe_bpm", int'(bpm_out), 0);
    check("late_strobe_active", int'(active), 0);

    idle(10);
    check("req_queue_drained", req_q.size(), 0);
    check("bpm_queue_drained", bpm_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
